uart_program_loader: RTL and testbench

- Receives program records from a host over an 8N1 UART line and turns them into write strobes for the processor's program (text) memory.
- Drives `program_write`, `program_cmd` and `uart_address` of the processor wrapper, so it sits directly upstream of the text RAM write port.
- Asserts `loading` while a download is in progress; top level uses it to hold the core in reset.

---
 rtl/uart_program_loader.sv | 190 +++++++++++++++++++
 tb/tb_uart_program_loader.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_program_loader.sv
// UART program loader: receives 3-byte {address, cmd-high, cmd-low} records over an 8N1 line
// and issues text-RAM write strobes. Define LOADER_PARITY_EN for 8E1 framing with parity checking.
module uart_program_loader #(
    parameter int CLKS_PER_BIT = 434,
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 12,
    parameter int TIMEOUT_CLKS = 16 * 10 * 434
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx,
    output logic                  program_write,
    output logic [DATA_WIDTH-1:0] program_cmd,
    output logic [ADDR_WIDTH-1:0] uart_address,
    output logic                  loading,
    output logic                  frame_error
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);

`ifdef LOADER_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} rxState_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} rxState_t;
`endif

    rxState_t        r_state;
    logic            r_rxMeta;
    logic            r_rxSync;
    logic            r_rxPrev;
    logic [CW-1:0]   r_bitCnt;
    logic [2:0]      r_bitIdx;
    logic [7:0]      r_shift;
`ifdef LOADER_PARITY_EN
    logic            r_parityBad;
`endif

    logic [1:0]      r_index;
    logic [7:0]      r_addrByte;
    logic [7:0]      r_highByte;
    logic [IW-1:0]   r_idleCnt;

    logic            w_expire;
    logic            w_stopSample;
    logic            w_byteAccept;
    logic            w_byteReject;
    logic            w_timeout;
    logic [1:0]      w_index;
    logic [15:0]     w_cmdFull;
    logic            w_unused;

    assign w_expire     = (r_bitCnt == '0);
    assign w_stopSample = (r_state == S_STOP) && w_expire;
`ifdef LOADER_PARITY_EN
    assign w_byteAccept = w_stopSample && r_rxSync && !r_parityBad;
`else
    assign w_byteAccept = w_stopSample && r_rxSync;
`endif
    assign w_byteReject = w_stopSample && !w_byteAccept;
    assign w_timeout    = (r_idleCnt == IW'(TIMEOUT_CLKS));
    // A byte landing on the timeout cycle starts a fresh record rather than extending the stale one.
    assign w_index      = w_timeout ? 2'd0 : r_index;
    assign w_cmdFull    = {r_highByte, r_shift};
    assign w_unused     = ^{r_addrByte, r_highByte, r_shift};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rxMeta    <= 1'b1;
            r_rxSync    <= 1'b1;
            r_rxPrev    <= 1'b1;
            r_state     <= S_IDLE;
            r_bitCnt    <= '0;
            r_bitIdx    <= 3'd0;
            r_shift     <= 8'd0;
`ifdef LOADER_PARITY_EN
            r_parityBad <= 1'b0;
`endif
        end else begin
            r_rxMeta <= rx;
            r_rxSync <= r_rxMeta;
            r_rxPrev <= r_rxSync;
            case (r_state)
                S_IDLE: begin
                    if (r_rxPrev && !r_rxSync) begin
                        r_state  <= S_START;
                        r_bitCnt <= HALF_LOAD;
                    end
                end
                S_START: begin
                    if (w_expire) begin
                        if (r_rxSync) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_state  <= S_DATA;
                            r_bitCnt <= FULL_LOAD;
                            r_bitIdx <= 3'd0;
                        end
                    end else begin
                        r_bitCnt <= r_bitCnt - 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_expire) begin
                        r_shift  <= {r_rxSync, r_shift[7:1]};
                        r_bitCnt <= FULL_LOAD;
                        r_bitIdx <= r_bitIdx + 3'd1;
                        if (r_bitIdx == 3'd7) begin
`ifdef LOADER_PARITY_EN
                            r_state <= S_PARITY;
`else
                            r_state <= S_STOP;
`endif
                        end
                    end else begin
                        r_bitCnt <= r_bitCnt - 1'b1;
                    end
                end
`ifdef LOADER_PARITY_EN
                S_PARITY: begin
                    if (w_expire) begin
                        r_parityBad <= r_rxSync ^ (^r_shift);
                        r_bitCnt    <= FULL_LOAD;
                        r_state     <= S_STOP;
                    end else begin
                        r_bitCnt <= r_bitCnt - 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (w_expire) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_bitCnt <= r_bitCnt - 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_index       <= 2'd0;
            r_addrByte    <= 8'd0;
            r_highByte    <= 8'd0;
            r_idleCnt     <= '0;
            program_write <= 1'b0;
            program_cmd   <= '0;
            uart_address  <= '0;
            loading       <= 1'b0;
            frame_error   <= 1'b0;
        end else begin
            program_write <= 1'b0;
            frame_error   <= 1'b0;
            if (w_byteAccept) begin
                r_idleCnt <= '0;
                loading   <= 1'b1;
                case (w_index)
                    2'd0: begin
                        r_addrByte <= r_shift;
                        r_index    <= 2'd1;
                    end
                    2'd1: begin
                        r_highByte <= r_shift;
                        r_index    <= 2'd2;
                    end
                    default: begin
                        uart_address  <= r_addrByte[ADDR_WIDTH-1:0];
                        program_cmd   <= w_cmdFull[DATA_WIDTH-1:0];
                        program_write <= 1'b1;
                        r_index       <= 2'd0;
                    end
                endcase
            end else if (w_byteReject) begin
                r_idleCnt   <= '0;
                frame_error <= 1'b1;
                r_index     <= 2'd0;
            end else if (w_timeout) begin
                r_index <= 2'd0;
                loading <= 1'b0;
            end else begin
                r_idleCnt <= r_idleCnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_program_loader.sv
// Randomized self-checking bench for uart_program_loader against a queue-based record model.
module tb_uart_program_loader;

    localparam int CPB        = 4;
    localparam int TO         = 200;
`ifdef LOADER_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx = 1'b1;
    logic        program_write;
    logic [11:0] program_cmd;
    logic [7:0]  uart_address;
    logic        loading;
    logic        frame_error;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0]  pending[$];
    logic [19:0] expWrites[$];
    logic [19:0] obsWrites[$];
    int expErrors = 0;
    int obsErrors = 0;
    int stableViol = 0;
    int pulseViol = 0;
    int idleAccum = 0;
    int obsBase = 0;
    int expBase = 0;

    logic [7:0]  prevAddr = 8'd0;
    logic [11:0] prevCmd = 12'd0;
    logic        prevWrite = 1'b0;

    uart_program_loader #(
        .CLKS_PER_BIT(CPB),
        .ADDR_WIDTH  (8),
        .DATA_WIDTH  (12),
        .TIMEOUT_CLKS(TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx           (rx),
        .program_write(program_write),
        .program_cmd  (program_cmd),
        .uart_address (uart_address),
        .loading      (loading),
        .frame_error  (frame_error)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Outputs may only change on the cycle the write strobe is high, and the strobe lasts one cycle.
    always @(negedge clk) begin
        if (reset) begin
            prevAddr  = uart_address;
            prevCmd   = program_cmd;
            prevWrite = 1'b0;
        end else begin
            if (program_write) begin
                obsWrites.push_back({uart_address, program_cmd});
                if (prevWrite) pulseViol++;
            end else if (uart_address !== prevAddr || program_cmd !== prevCmd) begin
                stableViol++;
            end
            if (frame_error) obsErrors++;
            prevAddr  = uart_address;
            prevCmd   = program_cmd;
            prevWrite = program_write;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic waitNeg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic idleCycles(input int n);
        rx = 1'b1;
        waitNeg(n);
        idleAccum += n;
    endtask

    // Sends one frame and advances the record model: three good bytes in a row make a write.
    task automatic applyStimulus(input logic [7:0] data, input logic goodStop);
        logic [7:0] a;
        logic [7:0] h;
        if (idleAccum + FRAME_BITS * CPB > TO) pending.delete();
        rx = 1'b0;
        waitNeg(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            waitNeg(CPB);
        end
`ifdef LOADER_PARITY_EN
        rx = ^data;
        waitNeg(CPB);
`endif
        rx = goodStop;
        waitNeg(CPB);
        rx = 1'b1;
        idleAccum = 0;
        if (goodStop) begin
            pending.push_back(data);
            if (pending.size() == 3) begin
                a = pending[0];
                h = pending[1];
                expWrites.push_back({a, h[3:0], pending[2]});
                pending.delete();
            end
        end else begin
            expErrors++;
            pending.delete();
        end
    endtask

    task automatic doReset();
        reset = 1'b1;
        rx = 1'b1;
        waitNeg(3);
        pending.delete();
        idleAccum = 0;
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_write"}, program_write, 1'b0);
        checkOutput({tag, "_err"}, frame_error, 1'b0);
        checkOutput({tag, "_loading"}, loading, 1'b0);
        checkOutput({tag, "_addr"}, uart_address, 8'h00);
        checkOutput({tag, "_cmd"}, program_cmd, 12'h000);
    endtask

    task automatic verifyWrites(input string tag);
        int n;
        idleCycles(4);
        checkOutput({tag, "_nwrites"}, obsWrites.size() - obsBase, expWrites.size() - expBase);
        n = obsWrites.size() - obsBase;
        if (expWrites.size() - expBase < n) n = expWrites.size() - expBase;
        for (int i = 0; i < n; i++)
            checkOutput({tag, "_write"}, obsWrites[obsBase + i], expWrites[expBase + i]);
        obsBase = obsWrites.size();
        expBase = expWrites.size();
        checkOutput({tag, "_frameErrors"}, obsErrors, expErrors);
        checkOutput({tag, "_stable"}, stableViol, 0);
        checkOutput({tag, "_pulseWidth"}, pulseViol, 0);
    endtask

    initial begin
        logic [7:0] b;
        logic       good;
        int         gap;

        waitNeg(3);
        checkIdleOutputs("resetAsserted");
        reset = 1'b0;
        idleCycles(100);
        checkIdleOutputs("resetIdle");
        verifyWrites("reset");

        applyStimulus(8'h05, 1'b1);
        applyStimulus(8'h0A, 1'b1);
        applyStimulus(8'h3C, 1'b1);
        verifyWrites("single");
        checkOutput("single_addr", uart_address, 8'h05);
        checkOutput("single_cmd", program_cmd, 12'hA3C);
        checkOutput("single_loadingHigh", loading, 1'b1);
        idleCycles(186);
        checkOutput("single_loadingHeld", loading, 1'b1);
        idleCycles(20);
        checkOutput("single_loadingFell", loading, 1'b0);

        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'h01, 1'b1);
        applyStimulus(8'h23, 1'b1);
        applyStimulus(8'hFF, 1'b1);
        applyStimulus(8'h0F, 1'b1);
        applyStimulus(8'hFF, 1'b1);
        verifyWrites("backToBack");

        applyStimulus(8'h10, 1'b1);
        applyStimulus(8'h02, 1'b1);
        idleCycles(250);
        checkOutput("timeout_loadingDropped", loading, 1'b0);
        applyStimulus(8'h20, 1'b1);
        applyStimulus(8'h03, 1'b1);
        applyStimulus(8'h45, 1'b1);
        verifyWrites("timeout");
        checkOutput("timeout_loadingBack", loading, 1'b1);

        applyStimulus(8'h50, 1'b1);
        applyStimulus(8'h66, 1'b0);
        idleCycles(4);
        applyStimulus(8'h07, 1'b1);
        applyStimulus(8'h01, 1'b1);
        applyStimulus(8'h11, 1'b1);
        verifyWrites("framing");

        rx = 1'b0;
        waitNeg(1);
        idleCycles(20);
        verifyWrites("glitch");

        applyStimulus(8'h30, 1'b1);
        applyStimulus(8'h04, 1'b1);
        doReset();
        checkIdleOutputs("midRecordReset");
        reset = 1'b0;
        idleCycles(10);
        applyStimulus(8'h31, 1'b1);
        applyStimulus(8'h05, 1'b1);
        applyStimulus(8'h67, 1'b1);
        verifyWrites("afterReset");

        for (int k = 0; k < 60; k++) begin
            b = 8'($urandom);
            good = ($urandom_range(0, 9) != 0);
            applyStimulus(b, good);
            if ($urandom_range(0, 7) == 0) begin
                gap = 250 + $urandom_range(0, 50);
                idleCycles(gap);
                checkOutput("random_timeoutLoading", loading, 1'b0);
            end else begin
                gap = $urandom_range(0, 40);
                if (!good && gap < 4) gap = 4;
                idleCycles(gap);
            end
        end
        verifyWrites("random");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
